register_bank: RTL and testbench

Parametrised bank of DEPTH clocked registers, each WIDTH bits wide, with one write/modify port and two read ports. Replaces the single-bit storage elements in the CPU datapath: every register is updated on the rising clock edge, and a per-cycle operation code selects hold, load, increment or decrement of the addressed register. It feeds the ALU operand buses through the A and B read ports and reports counter wrap-around on a registered flag.

---
 rtl/register_bank.sv | 88 ++++++++
 tb/tb_register_bank.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Bank of DEPTH registers with one hold/load/increment/decrement port and two
// combinational read ports, plus a registered flag reporting counter wrap-around.
module register_bank #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        OP,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] RADDR_A,
    input  logic [ADDR_W-1:0] RADDR_B,
    output logic [WIDTH-1:0]  QA,
    output logic [WIDTH-1:0]  QB,
    output logic              WRAP
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    // One extra bit so the range check stays meaningful when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_wrap;

    logic             w_waddr_ok;
    logic             w_wr_ok;
    logic             w_byp_ok;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // An address is usable when it exists and is not the hard-wired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !(ZERO_REG && (a == '0));
    endfunction

    assign w_waddr_ok = addr_ok(WADDR);
    assign w_wr_ok    = (OP != OP_HOLD) && w_waddr_ok;
    assign w_byp_ok   = BYPASS && !RST && w_wr_ok;
    assign w_cur      = w_waddr_ok ? r_mem[WADDR] : '0;

    always_comb begin
        w_next = w_cur;
        w_wrap = 1'b0;
        case (OP)
            OP_LOAD: w_next = D;
            OP_INC: begin
                w_next = w_cur + 1'b1;
                w_wrap = w_wr_ok && (&w_cur);
            end
            OP_DEC: begin
                w_next = w_cur - 1'b1;
                w_wrap = w_wr_ok && (w_cur == '0);
            end
            default: w_next = w_cur;
        endcase
    end

    assign QA = (w_byp_ok && (RADDR_A == WADDR)) ? w_next :
                (addr_ok(RADDR_A) ? r_mem[RADDR_A] : '0);
    assign QB = (w_byp_ok && (RADDR_B == WADDR)) ? w_next :
                (addr_ok(RADDR_B) ? r_mem[RADDR_B] : '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrap <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[WADDR] <= w_next;
            end
            r_wrap <= w_wrap;
        end
    end

    assign WRAP = r_wrap;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench: two register_bank configurations share one randomized stimulus
// stream and are compared against a behavioural model of the register file.
module tb_register_bank;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [2:0]  waddr;
    logic [15:0] d;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] qa0, qb0, qa1, qb1;
    logic        wrap0, wrap1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Configuration 0: defaults (DEPTH 8, bypass on, no zero register).
    register_bank #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut0 (
        .CLK(clk), .RST(rst), .OP(op), .WADDR(waddr), .D(d),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b), .QA(qa0), .QB(qb0), .WRAP(wrap0)
    );

    // Configuration 1: DEPTH 6, bypass off, register 0 hard-wired to zero.
    register_bank #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut1 (
        .CLK(clk), .RST(rst), .OP(op), .WADDR(waddr), .D(d),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b), .QA(qa1), .QB(qb1), .WRAP(wrap1)
    );

    typedef struct {
        logic [15:0] qa0, qb0, qa1, qb1;
        logic        w0, w1;
    } exp_t;

    exp_t sb[$];

    // Reference model: plain integer arrays, one per configuration.
    int unsigned mem [2][8];
    bit          mwrap [2];
    int          cfg_depth [2] = '{8, 6};
    bit          cfg_zero  [2] = '{1'b0, 1'b1};
    bit          cfg_byp   [2] = '{1'b1, 1'b0};

    function automatic bit usable(int c, int a);
        return (a < cfg_depth[c]) && !(cfg_zero[c] && a == 0);
    endfunction

    function automatic int unsigned next_val(int c, int o, int a, int unsigned dv);
        int unsigned cur = mem[c][a];
        if (o == 1) return dv;
        if (o == 2) return (cur + 1) % 65536;
        return (cur + 65535) % 65536;
    endfunction

    function automatic int unsigned model_read(int c, bit r, int o, int wa, int unsigned dv, int ra);
        if (!r && cfg_byp[c] && o != 0 && usable(c, wa) && ra == wa) return next_val(c, o, wa, dv);
        if (usable(c, ra)) return mem[c][ra];
        return 0;
    endfunction

    // Apply one cycle of stimulus, record the expected outputs, advance the model.
    task automatic cycle(input bit r, input int o, input int wa, input int unsigned dv,
                         input int ra, input int rb);
        exp_t e;
        rst = r; op = 2'(o); waddr = 3'(wa); d = 16'(dv); raddr_a = 3'(ra); raddr_b = 3'(rb);
        e.qa0 = 16'(model_read(0, r, o, wa, dv, ra));
        e.qb0 = 16'(model_read(0, r, o, wa, dv, rb));
        e.qa1 = 16'(model_read(1, r, o, wa, dv, ra));
        e.qb1 = 16'(model_read(1, r, o, wa, dv, rb));
        e.w0  = mwrap[0];
        e.w1  = mwrap[1];
        sb.push_back(e);
        for (int c = 0; c < 2; c++) begin
            if (r) begin
                for (int k = 0; k < 8; k++) mem[c][k] = 0;
                mwrap[c] = 1'b0;
            end else if (o != 0 && usable(c, wa)) begin
                mwrap[c] = (o == 2 && mem[c][wa] == 65535) || (o == 3 && mem[c][wa] == 0);
                mem[c][wa] = next_val(c, o, wa, dv);
            end else begin
                mwrap[c] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("qa_cfg0",   qa0, e.qa0);
            chk("qb_cfg0",   qb0, e.qb0);
            chk("wrap_cfg0", {15'd0, wrap0}, {15'd0, e.w0});
            chk("qa_cfg1",   qa1, e.qa1);
            chk("qb_cfg1",   qb1, e.qb1);
            chk("wrap_cfg1", {15'd0, wrap1}, {15'd0, e.w1});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned dv;
        rst = 1'b1; op = 2'b00; waddr = '0; d = '0; raddr_a = '0; raddr_b = '0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 8; k++) mem[c][k] = 0;
            mwrap[c] = 1'b0;
        end
        // First reset edge brings the array out of its unknown power-up state.
        @(posedge clk);
        #1;

        // Reset state, then a reset that overrides a pending load.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 3, 16'h1234, 3, 2);
        cycle(1, 1, 3, 16'h5555, 3, 3);
        cycle(0, 0, 0, 0, 3, 5);
        // Load/readback.
        cycle(0, 1, 5, 16'hBEEF, 0, 0);
        cycle(0, 0, 0, 0, 5, 4);
        // Wrap up, wrap down, then WRAP drops on a hold.
        cycle(0, 1, 2, 16'hFFFF, 2, 2);
        cycle(0, 2, 2, 0, 2, 1);
        cycle(0, 3, 2, 0, 2, 2);
        cycle(0, 0, 0, 0, 2, 2);
        cycle(0, 0, 0, 0, 2, 2);
        // Same-cycle bypass of an increment on both ports.
        cycle(0, 1, 1, 7, 0, 0);
        cycle(0, 2, 1, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        // Register 0 under ZERO_REG, including a decrement that would wrap.
        cycle(0, 1, 0, 16'hAAAA, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // Out-of-range addresses for the six-entry bank.
        cycle(0, 1, 7, 16'h5555, 7, 6);
        cycle(0, 2, 6, 0, 7, 6);
        cycle(0, 0, 0, 0, 7, 6);

        // Randomized traffic, with data biased toward the wrap boundaries.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: dv = 0;
                1: dv = 16'hFFFF;
                default: dv = $urandom_range(0, 65535);
            endcase
            cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 3), $urandom_range(0, 7),
                  dv, $urandom_range(0, 7), $urandom_range(0, 7));
        end

        rst = 1'b0; op = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
